inst_group_queue: RTL and testbench

Superscalar front-end instruction queue that packs single decoded instructions arriving from the decode stage into SS-wide bundles. It buffers up to DEPTH bundles in a circular FIFO and presents the head bundle, with a per-lane valid mask, to rename/dispatch. It sits between decode and rename/dispatch. It adds three things: SS and DEPTH are generic, there is a flush for branch recovery, and an optional timeout seals partial bundles.

---
 rtl/rv32i_types.sv | 17 +
 rtl/inst_group_stager.sv | 84 ++++++++
 rtl/inst_group_queue.sv | 101 ++++++++++
 tb/tb_inst_group_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared front-end types: instruction entry, packed bundle and queue defaults.
// INST_GROUP_PARTIAL_EN enables timeout sealing of partial bundles.
package rv32i_types;

    localparam int INST_GROUP_SS      = 2;
    localparam int INST_GROUP_DEPTH   = 8;
    localparam int INST_GROUP_ENTRY_W = 128;
    localparam int INST_GROUP_TIMEOUT = 4;

    typedef logic [INST_GROUP_ENTRY_W-1:0] instruction_info_reg_t;

    typedef struct packed {
        instruction_info_reg_t [INST_GROUP_SS-1:0] lanes;
        logic [INST_GROUP_SS-1:0]                  mask;
    } inst_group_t;

endpackage

// File: rtl/inst_group_stager.sv
// Packs single instructions into an SS-lane bundle and raises a seal strobe.
// INST_GROUP_PARTIAL_EN adds an age counter that seals stale partial bundles.
module inst_group_stager
    import rv32i_types::*;
#(
    parameter int SS              = INST_GROUP_SS,
    parameter int ENTRY_W         = INST_GROUP_ENTRY_W,
    parameter int PARTIAL_TIMEOUT = INST_GROUP_TIMEOUT,
    parameter int IW              = (SS > 1) ? $clog2(SS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_full,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ENTRY_W-1:0]    in_inst,
    output logic                  seal,
    output logic [SS*ENTRY_W-1:0] seal_data,
    output logic [SS-1:0]         seal_mask
);

    logic [SS-1:0][ENTRY_W-1:0] lanes;
    logic [IW-1:0]              lane_idx;
    logic                       last;
    logic                       accept;
    logic                       full_seal;
    logic                       tmo_seal;

    assign last      = (lane_idx == IW'(SS - 1));
    assign in_ready  = !last || !fifo_full;
    assign accept    = in_valid && in_ready;
    assign full_seal = accept && last;
    assign seal      = !flush && (full_seal || tmo_seal);

`ifdef INST_GROUP_PARTIAL_EN
    logic [4:0] age;

    assign tmo_seal = (age == 5'(PARTIAL_TIMEOUT)) && !fifo_full
                   && !accept && (lane_idx != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (flush || accept || seal) begin
            age <= '0;
        end else if ((lane_idx != '0) && (age != 5'(PARTIAL_TIMEOUT))) begin
            age <= age + 5'd1;
        end
    end
`else
    assign tmo_seal = 1'b0;
`endif

    // A full seal folds the incoming instruction into the top lane.
    always_comb begin
        logic [SS-1:0][ENTRY_W-1:0] grp;
        grp = lanes;
        seal_mask = '0;
        if (full_seal) begin
            grp[SS-1] = in_inst;
            seal_mask = '1;
        end else begin
            for (int i = 0; i < SS; i++) begin
                seal_mask[i] = (IW'(i) < lane_idx);
            end
        end
        seal_data = grp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes    <= '0;
            lane_idx <= '0;
        end else if (flush || seal) begin
            lanes    <= '0;
            lane_idx <= '0;
        end else if (accept) begin
            lanes[lane_idx] <= in_inst;
            lane_idx        <= lane_idx + 1'b1;
        end
    end

endmodule

// File: rtl/inst_group_queue.sv
// Circular FIFO of SS-wide instruction bundles between decode and dispatch.
// Build with INST_GROUP_PARTIAL_EN to seal partial bundles after a timeout.
module inst_group_queue
    import rv32i_types::*;
#(
    parameter int SS              = INST_GROUP_SS,
    parameter int DEPTH           = INST_GROUP_DEPTH,
    parameter int ENTRY_W         = INST_GROUP_ENTRY_W,
    parameter int PARTIAL_TIMEOUT = INST_GROUP_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ENTRY_W-1:0]          in_inst,
    output logic                        out_valid,
    output logic [SS-1:0]               out_mask,
    output logic [SS*ENTRY_W-1:0]       out_bundle,
    input  logic                        out_pop,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [SS*ENTRY_W-1:0] mem_data [DEPTH];
    logic [SS-1:0]         mem_mask [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  seal;
    logic [SS*ENTRY_W-1:0] seal_data;
    logic [SS-1:0]         seal_mask;
    logic                  push;
    logic                  pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign push      = seal && !flush;
    assign pop       = out_pop && out_valid && !flush;

    inst_group_stager #(
        .SS              (SS),
        .ENTRY_W         (ENTRY_W),
        .PARTIAL_TIMEOUT (PARTIAL_TIMEOUT)
    ) u_stager (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fifo_full (full),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .seal      (seal),
        .seal_data (seal_data),
        .seal_mask (seal_mask)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[tail] <= seal_data;
            mem_mask[tail] <= seal_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; gate the head so idle outputs read as zero.
    always_comb begin
        out_mask   = out_valid ? mem_mask[head] : '0;
        out_bundle = '0;
        for (int i = 0; i < SS; i++) begin
            if (out_mask[i]) begin
                out_bundle[i*ENTRY_W +: ENTRY_W] =
                    mem_data[head][i*ENTRY_W +: ENTRY_W];
            end
        end
    end

endmodule

// File: tb/tb_inst_group_queue.sv
// Directed bench for inst_group_queue with SS=2, DEPTH=4.
// Covers fill/wrap, push+pop, flush, partial timeout and async reset.
module tb_inst_group_queue;

    localparam int SS = 2;
    localparam int DEPTH = 4;
    localparam int EW = 128;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [EW-1:0]     in_inst;
    logic              out_valid;
    logic [SS-1:0]     out_mask;
    logic [SS*EW-1:0]  out_bundle;
    logic              out_pop;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    int checks = 0;
    int errors = 0;

    inst_group_queue #(
        .SS              (SS),
        .DEPTH           (DEPTH),
        .ENTRY_W         (EW),
        .PARTIAL_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_mask   (out_mask),
        .out_bundle (out_bundle),
        .out_pop    (out_pop),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [EW-1:0] d);
        in_valid = 1'b1;
        in_inst  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_pop = 1'b1;
        step();
        out_pop = 1'b0;
    endtask

    function automatic logic [255:0] bun(input logic [EW-1:0] l1,
                                         input logic [EW-1:0] l0);
        return {l1, l0};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, 256'(out_valid), 256'(0));
        chk({tag, ".mask"}, 256'(out_mask), 256'(0));
        chk({tag, ".bundle"}, out_bundle, 256'(0));
        chk({tag, ".ready"}, 256'(in_ready), 256'(1));
        chk({tag, ".count"}, 256'(count), 256'(0));
        chk({tag, ".full"}, 256'(full), 256'(0));
        chk({tag, ".empty"}, 256'(empty), 256'(1));
    endtask

    task automatic scen_ab(input string tag);
        acc(128'hA);
        chk({tag, ".mid_valid"}, 256'(out_valid), 256'(0));
        acc(128'hB);
        chk({tag, ".valid"}, 256'(out_valid), 256'(1));
        chk({tag, ".mask"}, 256'(out_mask), 256'(2'b11));
        chk({tag, ".bundle"}, out_bundle, bun(128'hB, 128'hA));
        chk({tag, ".count"}, 256'(count), 256'(1));
        pop1();
        chk({tag, ".empty"}, 256'(empty), 256'(1));
    endtask

    initial begin
        int first;
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        out_pop  = 1'b0;
        #12;
        chk_reset_vals("rst");
        rst = 1'b1;
        step();

        scen_ab("ab");

        // Fill to full, block, then wrap the tail into slot 0.
        for (int i = 1; i <= 8; i++) acc(128'(i));
        chk("fill.count", 256'(count), 256'(4));
        chk("fill.full", 256'(full), 256'(1));
        chk("fill.head", out_bundle, bun(128'd2, 128'd1));
        acc(128'd9);
        chk("fill.ready0", 256'(in_ready), 256'(0));
        in_valid = 1'b1;
        in_inst  = 128'd10;
        out_pop  = 1'b1;
        step();
        out_pop = 1'b0;
        chk("wrap.count3", 256'(count), 256'(3));
        chk("wrap.ready1", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0;
        chk("wrap.count4", 256'(count), 256'(4));
        chk("wrap.h2", out_bundle, bun(128'd4, 128'd3));
        pop1();
        chk("wrap.h3", out_bundle, bun(128'd6, 128'd5));
        pop1();
        chk("wrap.h4", out_bundle, bun(128'd8, 128'd7));
        pop1();
        chk("wrap.h5", out_bundle, bun(128'd10, 128'd9));
        pop1();
        chk("wrap.empty", 256'(empty), 256'(1));

        // Push and pop in the same cycle.
        acc(128'd11); acc(128'd12); acc(128'd13); acc(128'd14); acc(128'd15);
        chk("pp.pre", 256'(count), 256'(2));
        in_valid = 1'b1;
        in_inst  = 128'd16;
        out_pop  = 1'b1;
        step();
        in_valid = 1'b0;
        out_pop  = 1'b0;
        chk("pp.count", 256'(count), 256'(2));
        chk("pp.head", out_bundle, bun(128'd14, 128'd13));
        pop1();
        chk("pp.tail", out_bundle, bun(128'd16, 128'd15));
        pop1();

        // Flush beats a concurrent accept.
        for (int i = 21; i <= 27; i++) acc(128'(i));
        chk("fl.pre", 256'(count), 256'(3));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 128'd28;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.count", 256'(count), 256'(0));
        chk("fl.empty", 256'(empty), 256'(1));
        chk("fl.valid", 256'(out_valid), 256'(0));
        acc(128'd31); acc(128'd32);
        chk("fl.lane0", out_bundle, bun(128'd32, 128'd31));
        pop1();

        // Partial bundle behaviour.
        acc(128'hC);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid && first < 0) first = i;
        end
`ifdef INST_GROUP_PARTIAL_EN
        chk("part.when", 256'(first), 256'(5));
        chk("part.mask", 256'(out_mask), 256'(2'b01));
        chk("part.bundle", out_bundle, bun(128'd0, 128'hC));
        pop1();
`else
        chk("part.valid", 256'(out_valid), 256'(0));
        chk("part.never", 256'(first + 1), 256'(0));
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif
        chk("part.empty", 256'(empty), 256'(1));

        // Asynchronous reset mid-stream.
        acc(128'd41); acc(128'd42); acc(128'd43); acc(128'd44);
        chk("ar.pre", 256'(count), 256'(2));
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("ar");
        #3;
        rst = 1'b1;
        step();
        scen_ab("ar.ab");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
